uart_rx_fifo: RTL

- Serial receive stage that consumes the TX line driven by the string-transmit block (8N1, LSB first, idle high).
- Recovers bytes with its own bit-timing counter and queues them in a small first-word-fall-through (FWFT) FIFO for a downstream consumer, e.g. a display or loopback checker.
- Flags framing errors and FIFO overflow.

---
 rtl/uart_rx_fifo.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with even-parity checking.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 2604,
   parameter int FIFO_AW = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_in,
   input  logic               rd_en,
   output logic [7:0]         rd_data,
   output logic               empty,
   output logic               full,
   output logic [FIFO_AW:0]   count,
   output logic               frame_err,
   output logic               parity_err,
   output logic               ovf,
   input  logic               ovf_clr
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0] CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

   logic [1:0]       sync_q;
   logic             rx_s;
   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic             push_q;
   logic             frame_err_q;
   logic             ovf_q;
   logic             ovf_d;
   logic             push_ok;
   logic             pop;
   logic [FIFO_AW:0] wp_q;
   logic [FIFO_AW:0] rp_q;
   logic [7:0]       mem_q [DEPTH];
`ifdef UART_RX_PARITY_EN
   logic             par_q;
   logic             parity_err_q;
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign rx_s = sync_q[1];
   assign frame_err = frame_err_q;

   // Counter free-runs and wraps each bit; every state change reloads it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= 2'b11;
         state_q <= IDLE;
         cnt_q <= '0;
         bit_q <= '0;
         shift_q <= '0;
         push_q <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         sync_q <= {sync_q[0], rx_in};
         push_q <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
         case (state_q)
            IDLE: if (!rx_s) begin
               state_q <= START;
               cnt_q <= '0;
            end
            START: if (cnt_q == HALF) begin
               state_q <= rx_s ? IDLE : DATA;
               cnt_q <= '0;
               bit_q <= '0;
            end
            DATA: if (cnt_q == LAST) begin
               shift_q <= {rx_s, shift_q[7:1]};
               bit_q <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (bit_q == 3'd7) state_q <= PAR;
`else
               if (bit_q == 3'd7) state_q <= STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PAR: if (cnt_q == LAST) begin
               par_q <= rx_s;
               state_q <= STOP;
            end
`endif
            STOP: if (cnt_q == LAST) begin
               state_q <= rx_s ? IDLE : BRK;
               frame_err_q <= !rx_s;
`ifdef UART_RX_PARITY_EN
               parity_err_q <= rx_s && (par_q != ^shift_q);
               push_q <= rx_s && (par_q == ^shift_q);
`else
               push_q <= rx_s;
`endif
            end
            BRK: if (rx_s) begin
               state_q <= IDLE;
               cnt_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign count = wp_q - rp_q;
   assign empty = (count == '0);
   assign full = (count == CNT_FULL);
   assign pop = rd_en && !empty;
   assign push_ok = push_q && (!full || rd_en);
   assign ovf_d = (push_q && full && !rd_en) || (ovf_q && !ovf_clr);
   assign ovf = ovf_q;
   assign rd_data = empty ? 8'h00 : mem_q[rp_q[FIFO_AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q <= '0;
         rp_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (push_ok) wp_q <= wp_q + (FIFO_AW+1)'(1);
         if (pop) rp_q <= rp_q + (FIFO_AW+1)'(1);
         ovf_q <= ovf_d;
      end
   end

   // When full with a concurrent pop, the write lands in the slot being vacated.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wp_q[FIFO_AW-1:0]] <= shift_q;
   end
endmodule
